// File: rtl/mem_pkg.sv
// Shared types and lane/extension helpers for the memory-access stage.
package mem_pkg;

  // Nine operations need four bits.
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LBU      = 4'd2,
    LH       = 4'd3,
    LHU      = 4'd4,
    LW       = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [1:0]  off;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        needs_resp;
    logic        done;
    logic        exc;
  } trk_entry_t;

  function automatic logic is_load(mem_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_wen(mem_op_t op, logic [1:0] off);
    case (op)
      SB:      return 4'b0001 << off;
      SH:      return 4'b0011 << {off[1], 1'b0};
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(mem_op_t op, logic [1:0] off, logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_tracker.sv
// In-order tracker FIFO: alloc at tail, load completion at the oldest pending load, pop at head.
module mem_tracker_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_i,
  input  trk_entry_t  alloc_entry_i,
  input  logic        pop_i,
  input  logic        resp_i,
  input  logic [31:0] resp_data_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        head_done_o,
  output logic        head_exc_o,
  output logic [4:0]  head_dest_o,
  output logic [31:0] head_data_o,
  output logic        resp_pending_o,
  output mem_op_t     resp_op_o,
  output logic [1:0]  resp_off_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  trk_entry_t    mem_q [DEPTH];
  logic [PW-1:0] alloc_q, head_q, resp_q, resp_d;
  logic [PW-1:0] resp_span, scan_idx, pend_ptr;
  logic          pend_found;

  always_comb begin
    full_o      = (alloc_q[IW] != head_q[IW]) && (alloc_q[IW-1:0] == head_q[IW-1:0]);
    empty_o     = alloc_q == head_q;
    head_done_o = mem_q[head_q[IW-1:0]].done;
    head_exc_o  = mem_q[head_q[IW-1:0]].exc;
    head_dest_o = mem_q[head_q[IW-1:0]].dest;
    head_data_o = mem_q[head_q[IW-1:0]].data;
  end

  // resp_q may sit on stores/ALU ops; the scan skips them so back-to-back responses land correctly.
  always_comb begin
    resp_span  = alloc_q - resp_q;
    pend_found = 1'b0;
    pend_ptr   = alloc_q;
    scan_idx   = resp_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = resp_q + PW'(i);
      if (!pend_found && (PW'(i) < resp_span) &&
          mem_q[scan_idx[IW-1:0]].needs_resp && !mem_q[scan_idx[IW-1:0]].done) begin
        pend_found = 1'b1;
        pend_ptr   = scan_idx;
      end
    end
    if (resp_i && pend_found) resp_d = pend_ptr + PW'(1);
    else                      resp_d = pend_ptr;
    resp_pending_o = pend_found;
    resp_op_o      = mem_q[pend_ptr[IW-1:0]].op;
    resp_off_o     = mem_q[pend_ptr[IW-1:0]].off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q <= '0;
      head_q  <= '0;
      resp_q  <= '0;
    end else begin
      resp_q <= resp_d;
      if (alloc_i) begin
        mem_q[alloc_q[IW-1:0]] <= alloc_entry_i;
        alloc_q                <= alloc_q + PW'(1);
      end
      if (pop_i) head_q <= head_q + PW'(1);
      if (resp_i && pend_found) begin
        mem_q[pend_ptr[IW-1:0]].data <= resp_data_i;
        mem_q[pend_ptr[IW-1:0]].done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory-access stage: lane-correct SRAM requests, in-order results to writeback.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  mem_op_t           in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [4:0]        in_rt_num,
  input  logic [31:0]       in_rt_data,
  input  logic [4:0]        in_dest,
  input  logic [31:0]       in_alu_data,
  input  logic              fwd_wb_wen,
  input  logic [4:0]        fwd_wb_reg,
  input  logic [31:0]       fwd_wb_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_wen,
  output logic [31:0]       req_wdata,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_dest,
  output logic [31:0]       out_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              out_exc
`endif
);

  logic        mis, needs_req, accept, pop, resp_en;
  logic        full, empty, head_done, head_exc, resp_pending;
  logic [4:0]  head_dest;
  logic [31:0] head_data, rt_val;
  mem_op_t     resp_op;
  logic [1:0]  resp_off;
  trk_entry_t  alloc_entry;

  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    mis = misaligned(in_op, in_addr[1:0]);
`else
    mis = 1'b0;
`endif
    needs_req = (in_op != MEM_NONE) && !mis;
    in_ready  = !reset && !full && (!needs_req || req_ready);
    req_valid = !reset && in_valid && !full && needs_req;
    accept    = in_valid && in_ready;
  end

  always_comb begin
    rt_val = (fwd_wb_wen && (fwd_wb_reg != 5'd0) && (fwd_wb_reg == in_rt_num)) ? fwd_wb_data
                                                                               : in_rt_data;
    req_addr = {in_addr[ADDR_W-1:2], 2'b00};
    req_wen  = lane_wen(in_op, in_addr[1:0]);
    case (in_op)
      SB:      req_wdata = {4{rt_val[7:0]}};
      SH:      req_wdata = {2{rt_val[15:0]}};
      SW:      req_wdata = rt_val;
      default: req_wdata = '0;
    endcase
  end

  always_comb begin
    alloc_entry.op         = in_op;
    alloc_entry.off        = in_addr[1:0];
    alloc_entry.dest       = mis ? 5'd0 : in_dest;
    alloc_entry.data       = is_load(in_op) ? '0 : in_alu_data;
    alloc_entry.needs_resp = is_load(in_op) && !mis;
    alloc_entry.done       = !(is_load(in_op) && !mis);
    alloc_entry.exc        = mis;
  end

  always_comb begin
    out_valid = !reset && !empty && head_done;
    out_dest  = out_valid ? head_dest : '0;
    out_data  = out_valid ? head_data : '0;
    pop       = out_valid && out_ready;
    resp_en   = !reset && resp_valid && resp_pending;
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb out_exc = out_valid && head_exc;
`else
  logic unused_head_exc;
  always_comb unused_head_exc = head_exc;
`endif

  mem_tracker_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tracker (
    .clk            (clk),
    .reset          (reset),
    .alloc_i        (accept),
    .alloc_entry_i  (alloc_entry),
    .pop_i          (pop),
    .resp_i         (resp_en),
    .resp_data_i    (load_extract(resp_op, resp_off, resp_rdata)),
    .full_o         (full),
    .empty_o        (empty),
    .head_done_o    (head_done),
    .head_exc_o     (head_exc),
    .head_dest_o    (head_dest),
    .head_data_o    (head_data),
    .resp_pending_o (resp_pending),
    .resp_op_o      (resp_op),
    .resp_off_o     (resp_off)
  );

  a_resp_without_load: assert property (@(posedge clk) disable iff (reset)
    resp_valid |-> resp_pending);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic against an in-order queue model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned N  = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, fwd_wb_wen, req_valid, req_ready;
  logic          resp_valid, out_valid, out_ready;
  mem_op_t       in_op;
  logic [AW-1:0] in_addr, req_addr;
  logic [4:0]    in_rt_num, in_dest, fwd_wb_reg, out_dest;
  logic [31:0]   in_rt_data, in_alu_data, fwd_wb_data, req_wdata, resp_rdata, out_data;
  logic [3:0]    req_wen;
`ifdef MEM_ALIGN_CHECK_EN
  logic          out_exc;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .MAX_OUTSTANDING(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_rt_num(in_rt_num), .in_rt_data(in_rt_data), .in_dest(in_dest),
    .in_alu_data(in_alu_data), .fwd_wb_wen(fwd_wb_wen), .fwd_wb_reg(fwd_wb_reg),
    .fwd_wb_data(fwd_wb_data), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .out_data(out_data)
`ifdef MEM_ALIGN_CHECK_EN
    , .out_exc(out_exc)
`endif
  );

  typedef struct { logic [4:0] dest; logic [31:0] data; bit done; bit exc; bit chk_data; } rec_t;
  typedef struct { int unsigned seq; mem_op_t op; int unsigned off; int unsigned cyc; } ld_t;

  rec_t        rec[$];
  ld_t         pend[$];
  int unsigned seq_n = 0, pop_n = 0, cyc_n = 0;
  int          n_checks = 0, n_errors = 0;

  bit          s_reset, s_valid, s_fwen, s_req_ready, s_resp, s_out_ready;
  mem_op_t     s_op;
  logic [31:0] s_addr, s_rt_data, s_alu, s_fdata, s_rdata;
  logic [4:0]  s_rt_num, s_dest, s_freg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic bit bm_load(mem_op_t op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction

  function automatic bit bm_store(mem_op_t op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic bit bm_mis(mem_op_t op, logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    if (op == LW || op == SW) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] bm_wen(mem_op_t op, logic [31:0] a);
    if (op == SB) return 32'd1 << (a % 4);
    if (op == SH) return 32'd3 << (a & 2);
    if (op == SW) return 32'hF;
    return 32'd0;
  endfunction

  function automatic logic [31:0] bm_wdata(mem_op_t op, logic [31:0] v);
    if (op == SB) return (v & 32'hFF) * 32'h0101_0101;
    if (op == SH) return (v & 32'hFFFF) * 32'h0001_0001;
    return v;
  endfunction

  function automatic logic [31:0] bm_extract(mem_op_t op, int unsigned off, logic [31:0] rd);
    logic [31:0] v;
    if (op == LW) return rd;
    if (op == LH || op == LHU) begin
      v = (rd >> ((off & 2) * 8)) & 32'hFFFF;
      if (op == LH && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = (rd >> (off * 8)) & 32'hFF;
      if (op == LB && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic step();
    bit          full, mis, nreq, e_rdy, e_req, e_out;
    logic [31:0] rt;
    rec_t        r;
    ld_t         ld;
    @(negedge clk);
    reset = s_reset; in_valid = s_valid; in_op = s_op; in_addr = s_addr;
    in_rt_num = s_rt_num; in_rt_data = s_rt_data; in_dest = s_dest; in_alu_data = s_alu;
    fwd_wb_wen = s_fwen; fwd_wb_reg = s_freg; fwd_wb_data = s_fdata;
    req_ready = s_req_ready; out_ready = s_out_ready; resp_rdata = s_rdata;
    resp_valid = s_resp && !s_reset && pend.size() > 0 && pend[0].cyc < cyc_n;
    #1;
    full  = rec.size() >= N;
    mis   = bm_mis(s_op, s_addr);
    nreq  = s_op != MEM_NONE && !mis;
    e_rdy = !s_reset && !full && (!nreq || s_req_ready);
    e_req = !s_reset && s_valid && !full && nreq;
    e_out = !s_reset && rec.size() > 0 && rec[0].done;
    check_eq("in_ready", 32'(in_ready), 32'(e_rdy));
    check_eq("req_valid", 32'(req_valid), 32'(e_req));
    check_eq("out_valid", 32'(out_valid), 32'(e_out));
    if (e_req) begin
      rt = (s_fwen && s_freg != 0 && s_freg == s_rt_num) ? s_fdata : s_rt_data;
      check_eq("req_addr", req_addr, s_addr & 32'hFFFF_FFFC);
      check_eq("req_wen", 32'(req_wen), bm_wen(s_op, s_addr));
      if (bm_store(s_op)) check_eq("req_wdata", req_wdata, bm_wdata(s_op, rt));
    end
    if (e_out) begin
      check_eq("out_dest", 32'(out_dest), 32'(rec[0].dest));
      if (rec[0].chk_data) check_eq("out_data", out_data, rec[0].data);
`ifdef MEM_ALIGN_CHECK_EN
      check_eq("out_exc", 32'(out_exc), 32'(rec[0].exc));
`endif
    end
    if (s_reset) begin
      rec.delete(); pend.delete(); pop_n = seq_n;
    end else begin
      if (e_out && s_out_ready) begin void'(rec.pop_front()); pop_n++; end
      if (resp_valid) begin
        ld = pend.pop_front();
        rec[ld.seq - pop_n].data     = bm_extract(ld.op, ld.off, s_rdata);
        rec[ld.seq - pop_n].done     = 1'b1;
        rec[ld.seq - pop_n].chk_data = 1'b1;
      end
      if (s_valid && e_rdy) begin
        r.dest = mis ? 5'd0 : s_dest;
        r.data = s_alu;
        r.exc  = mis;
        r.done = !(bm_load(s_op) && !mis);
        r.chk_data = (s_op == MEM_NONE);
        rec.push_back(r);
        if (bm_load(s_op) && !mis) begin
          ld.seq = seq_n; ld.op = s_op; ld.off = s_addr % 4; ld.cyc = cyc_n;
          pend.push_back(ld);
        end
        seq_n++;
      end
    end
    cyc_n++;
  endtask

  task automatic clear_stage();
    s_reset = 0; s_valid = 0; s_op = MEM_NONE; s_addr = '0; s_rt_num = '0; s_rt_data = '0;
    s_dest = '0; s_alu = '0; s_fwen = 0; s_freg = '0; s_fdata = '0; s_req_ready = 1;
    s_resp = 0; s_rdata = '0; s_out_ready = 1;
  endtask

  task automatic issue(input mem_op_t op, input logic [31:0] addr, input logic [4:0] dest,
                       input logic [31:0] val);
    s_valid = 1; s_op = op; s_addr = addr; s_dest = dest; s_rt_data = val; s_alu = val;
    step();
    s_valid = 0;
  endtask

  task automatic drain();
    s_valid = 0; s_out_ready = 1; s_resp = 1;
    for (int i = 0; i < 40 && rec.size() > 0; i++) step();
    check_eq("drain_empty", 32'(rec.size()), 32'd0);
    s_resp = 0;
  endtask

  initial begin
    clear_stage();
    // Reset: handshake outputs held low even with a pending input.
    s_reset = 1; s_valid = 1; s_op = LW;
    step(); step();
    clear_stage();
    step();
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_dest", 32'(out_dest), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("rst_out_exc", 32'(out_exc), 32'd0);
`endif

    s_rt_num = 5'd3;
    issue(SB, 32'h1002, 5'd0, 32'h1234_56AB);
    check_eq("sb_addr", req_addr, 32'h1000);
    check_eq("sb_wen", 32'(req_wen), 32'h4);
    check_eq("sb_wdata", req_wdata, 32'hABAB_ABAB);
    step();
    check_eq("sb_out_valid", 32'(out_valid), 32'd1);

    issue(LH, 32'h2002, 5'd7, 32'h0);
    s_resp = 1; s_rdata = 32'h8001_7F00; step(); s_resp = 0;
    step();
    check_eq("lh_data", out_data, 32'hFFFF_8001);
    issue(LHU, 32'h2002, 5'd8, 32'h0);
    s_resp = 1; step(); s_resp = 0;
    step();
    check_eq("lhu_data", out_data, 32'h0000_8001);

    s_fwen = 1; s_freg = 5'd5; s_rt_num = 5'd5; s_fdata = 32'hDEAD_BEEF;
    issue(SW, 32'h40, 5'd0, 32'h0102_0304);
    check_eq("fwd_wdata", req_wdata, 32'hDEAD_BEEF);
    s_freg = 5'd0; s_rt_num = 5'd0;
    issue(SW, 32'h44, 5'd0, 32'h0102_0304);
    check_eq("nofwd_wdata", req_wdata, 32'h0102_0304);
    s_fwen = 0;
    drain();

    // LW, ADD, LW with slow responses: ADD must wait behind the first load.
    issue(LW, 32'h100, 5'd1, 32'h0);
    issue(MEM_NONE, 32'h0, 5'd9, 32'h55);
    issue(LW, 32'h104, 5'd2, 32'h0);
    s_rdata = 32'hCAFE_0001; s_resp = 1; step(); s_resp = 0;
    step();
    s_rdata = 32'hCAFE_0002; s_resp = 1; step(); s_resp = 0;
    step(); step();
    drain();

    // Fill with loads, then free one slot.
    s_out_ready = 0;
    for (int i = 0; i < 4; i++) issue(LW, 32'h200 + 32'(i * 4), 5'(10 + i), 32'h0);
    s_valid = 1; s_op = LW; s_addr = 32'h300;
    step();
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    s_resp = 1; s_rdata = 32'h1111_2222; step(); s_resp = 0;
    s_out_ready = 1; step();
    check_eq("full_pop_in_ready", 32'(in_ready), 32'd0);
    s_out_ready = 0; step();
    check_eq("after_pop_in_ready", 32'(in_ready), 32'd1);
    s_valid = 0;
    s_reset = 1; step(); s_reset = 0;
    s_valid = 1; s_op = MEM_NONE; s_dest = 5'd4; s_alu = 32'h77;
    step();
    check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_empty", 32'(in_ready), 32'd1);
    drain();

`ifdef MEM_ALIGN_CHECK_EN
    issue(LW, 32'h3001, 5'd12, 32'h0);
    check_eq("mis_req_valid", 32'(req_valid), 32'd0);
    s_out_ready = 1; step();
    check_eq("mis_exc", 32'(out_exc), 32'd1);
    check_eq("mis_dest", 32'(out_dest), 32'd0);
    drain();
`endif

    for (int c = 0; c < 3000; c++) begin
      s_reset     = ($urandom_range(0, 599) == 0);
      s_valid     = ($urandom_range(0, 3) != 0);
      s_op        = mem_op_t'($urandom_range(0, 8));
      s_addr      = $urandom;
      s_rt_num    = 5'($urandom_range(0, 31));
      s_rt_data   = $urandom;
      s_dest      = 5'($urandom_range(0, 31));
      s_alu       = $urandom;
      s_fwen      = 1'($urandom_range(0, 1));
      s_freg      = ($urandom_range(0, 1) != 0) ? s_rt_num : 5'($urandom_range(0, 31));
      s_fdata     = $urandom;
      s_req_ready = ($urandom_range(0, 3) != 0);
      s_resp      = ($urandom_range(0, 2) != 0);
      s_rdata     = $urandom;
      s_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    clear_stage();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
